// File: rtl/divider_arbiter.sv
// Round-robin sequencer sharing one subtractor divider among NUM_REQ clients.
// Traps zero divisors and divider hangs; owns every divider start and reset.
module divider_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] a_bus,
    input  logic [NUM_REQ*N-1:0] b_bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [N-1:0]         quotient_out,
    output logic [N-1:0]         remainder_out,
    output logic                 err,
    output logic                 div_start,
    output logic [N-1:0]         div_in1,
    output logic [N-1:0]         div_in2,
    output logic                 div_reset,
    input  logic [N-1:0]         div_quotient,
    input  logic [N-1:0]         div_remainder,
    input  logic                 div_end
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;

    logic [IDW-1:0] winner_c;
    logic           found_c;
    int unsigned    idx_c;
    logic [N-1:0]   a_sel_c;
    logic [N-1:0]   b_sel_c;

    // First pending request after the pointer; scanning downward lets the nearest one win.
    always_comb begin
        winner_c = ptr;
        found_c  = 1'b0;
        idx_c    = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx_c = (32'(ptr) + 32'(k)) % NUM_REQ;
            if (req[IDW'(idx_c)]) begin
                winner_c = IDW'(idx_c);
                found_c  = 1'b1;
            end
        end
        a_sel_c = a_bus[32'(winner_c) * N +: N];
        b_sel_c = b_bus[32'(winner_c) * N +: N];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            ptr           <= IDW'(NUM_REQ - 1);
            cnt           <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            done_id       <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            err           <= 1'b0;
            div_start     <= 1'b0;
            div_in1       <= '0;
            div_in2       <= '0;
            div_reset     <= 1'b1;
        end else begin
            div_start <= 1'b0;
            div_reset <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found_c) begin
                        grant   <= NUM_REQ'(1) << winner_c;
                        ptr     <= winner_c;
                        div_in1 <= a_sel_c;
                        div_in2 <= b_sel_c;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (div_in2 == '0) begin
                        quotient_out  <= '1;
                        remainder_out <= div_in1;
                        err           <= 1'b1;
                        done          <= 1'b1;
                        done_id       <= ptr;
                        state         <= S_DONE;
                    end else begin
                        div_start <= 1'b1;
                        cnt       <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An end flag seen while div_start is still high belongs to the previous job.
                    if (div_end && !div_start) begin
                        quotient_out  <= div_quotient;
                        remainder_out <= div_remainder;
                        err           <= 1'b0;
                        done          <= 1'b1;
                        done_id       <= ptr;
                        state         <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        quotient_out  <= '0;
                        remainder_out <= '0;
                        err           <= 1'b1;
                        div_reset     <= 1'b1;
                        state         <= S_ABORT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ABORT: begin
                    done    <= 1'b1;
                    done_id <= ptr;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: transaction-timeline model plus directed scenarios.
module tb_divider_arbiter;

    localparam int unsigned N   = 8;
    localparam int unsigned NR  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned TO  = 300;
    localparam int          LAT = 3;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req   = '0;
    logic [NR*N-1:0] a_bus = '0;
    logic [NR*N-1:0] b_bus = '0;
    logic [NR-1:0]   grant;
    logic            busy, done, err, div_start, div_reset;
    logic [IDW-1:0]  done_id;
    logic [N-1:0]    quotient_out, remainder_out, div_in1, div_in2;
    logic [N-1:0]    div_quotient  = '0;
    logic [N-1:0]    div_remainder = '0;
    logic            div_end       = 1'b0;

    always #5 clk = ~clk;

    divider_arbiter #(.N(N), .NUM_REQ(NR), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .quotient_out(quotient_out), .remainder_out(remainder_out), .err(err),
        .div_start(div_start), .div_in1(div_in1), .div_in2(div_in2),
        .div_reset(div_reset), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_end(div_end)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Divider stand-in: result LAT cycles after start; end flag stays up until the next job begins.
    logic hang   = 1'b0;
    logic d_pend = 1'b0;
    int   d_cnt  = 0;
    logic [N-1:0] d_a = '0, d_b = '0;
    always @(negedge clk) begin
        if (div_reset) begin
            div_end = 1'b0;
            d_pend  = 1'b0;
        end else if (d_pend) begin
            div_end = 1'b0;
            if (d_cnt == 0) begin
                d_pend = 1'b0;
                if (!hang) begin
                    div_end       = 1'b1;
                    div_quotient  = d_a / d_b;
                    div_remainder = d_a % d_b;
                end
            end else begin
                d_cnt--;
            end
        end
        if (div_start && !div_reset) begin
            d_pend = 1'b1;
            d_cnt  = LAT;
            d_a    = div_in1;
            d_b    = div_in2;
        end
    end

    // Reference model: t counts cycles since the sampling edge (t=1 LOAD, t=2 first WAIT).
    logic         m_act = 1'b0;
    int           m_t = 0, m_done_at = 0, m_abort_at = 0, m_id = 0, m_ptr = NR - 1;
    logic [N-1:0] m_a = '0, m_b = '0;
    logic [N-1:0] e_q = '0, e_r = '0;
    logic         e_err = 1'b0, e_rst = 1'b1;
    int           e_id = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0; m_ptr = NR - 1; m_t = 0; m_done_at = 0; m_abort_at = 0;
            m_a = '0; m_b = '0; e_q = '0; e_r = '0; e_err = 1'b0; e_id = 0; e_rst = 1'b1;
        end else begin
            e_rst = 1'b0;
            if (!m_act) begin
                if (req != '0) begin
                    for (int k = 1; k <= int'(NR); k++) begin
                        int c;
                        c = (m_ptr + k) % NR;
                        if (req[c]) begin
                            m_id = c;
                            break;
                        end
                    end
                    m_ptr = m_id; m_act = 1'b1; m_t = 1; m_abort_at = 0;
                    m_a = a_bus[m_id*N +: N];
                    m_b = b_bus[m_id*N +: N];
                    if (m_b == 0) begin
                        m_done_at = 2; e_q = '1; e_r = m_a; e_err = 1'b1; e_id = m_id;
                    end else begin
                        m_done_at = 0;
                    end
                end
            end else if (m_t == m_done_at) begin
                m_act = 1'b0;
            end else begin
                if (m_done_at == 0 && m_t >= 2) begin
                    if (m_t > 2 && div_end) begin
                        m_done_at = m_t + 1; e_q = m_a / m_b; e_r = m_a % m_b;
                        e_err = 1'b0; e_id = m_id;
                    end else if (m_t == int'(TO) + 1) begin
                        m_abort_at = m_t + 1; m_done_at = m_t + 2;
                        e_q = '0; e_r = '0; e_err = 1'b1; e_id = m_id;
                    end
                end
                m_t++;
            end
        end
    end

    // Per-cycle compare plus event logging for the directed checks.
    int            n_done = 0, n_start = 0, n_drst = 0;
    logic [N-1:0]  st_a = '0, st_b = '0;
    int            glog[$];
    logic [NR-1:0] prev_grant = '0;
    logic [NR-1:0] eg;
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst busy", busy, 0);
            chk("rst grant", grant, 0);
            chk("rst done", done, 0);
            chk("rst done_id", done_id, 0);
            chk("rst quotient", quotient_out, 0);
            chk("rst remainder", remainder_out, 0);
            chk("rst err", err, 0);
            chk("rst div_start", div_start, 0);
            chk("rst div_in", {div_in1, div_in2}, 0);
            chk("rst div_reset", div_reset, 1);
        end else begin
            eg = m_act ? (NR'(1) << m_id) : '0;
            chk("busy", busy, m_act);
            chk("grant", grant, eg);
            chk("div_start", div_start, m_act && m_b != 0 && m_t == 2);
            chk("div_reset", div_reset, e_rst || (m_act && m_t == m_abort_at));
            chk("done", done, m_act && m_t == m_done_at);
            if (!m_act || m_t == m_done_at) begin
                chk("quotient", quotient_out, e_q);
                chk("remainder", remainder_out, e_r);
                chk("err", err, e_err);
                chk("done_id", done_id, e_id);
            end
            if (m_act) begin
                chk("div_in1", div_in1, m_a);
                chk("div_in2", div_in2, m_b);
            end
            if (done) n_done++;
            if (div_reset) n_drst++;
            if (div_start) begin
                n_start++; st_a = div_in1; st_b = div_in2;
            end
            if (grant != '0 && grant != prev_grant)
                for (int i = 0; i < int'(NR); i++) if (grant[i]) glog.push_back(i);
        end
        prev_grant = grant;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_bus[i*N +: N] = a;
        b_bus[i*N +: N] = b;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        req = '0;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        glog.delete();
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        step();
        while (!(done && reset) && c < 1000) begin
            step();
            c++;
        end
        chk({name, " done bound"}, c < 1000, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int s0, d0, r0, gcnt;

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("t0 reset div_reset", div_reset, 1);
        chk("t0 reset grant", grant, 0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // 1: single division
        put(0, 8'd100, 8'd7);
        wait_done("t1");
        chk("t1 start count", n_start, 1);
        chk("t1 div_in1", st_a, 100);
        chk("t1 div_in2", st_b, 7);
        chk("t1 done_id", done_id, 0);
        chk("t1 quotient", quotient_out, 14);
        chk("t1 remainder", remainder_out, 2);
        chk("t1 err", err, 0);
        req = '0;

        // 2: all four requesting, rotation from a fresh reset
        do_reset();
        for (int i = 0; i < int'(NR); i++) put(i, N'(30 + 17 * i), N'(i + 2));
        s0 = n_start;
        for (int i = 0; i < 6; i++) begin
            wait_done("t2");
            chk("t2 done_id order", done_id, exp_order[i]);
        end
        req = '0;
        chk("t2 grant count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2 grant order", glog[i], exp_order[i]);
        chk("t2 starts per grant", n_start - s0, 6);

        // 3: zero divisor
        step();
        s0 = n_start;
        put(2, 8'd55, 8'd0);
        step();
        chk("t3 no done at LOAD", done, 0);
        step();
        chk("t3 done", done, 1);
        chk("t3 done_id", done_id, 2);
        chk("t3 quotient", quotient_out, 8'hFF);
        chk("t3 remainder", remainder_out, 55);
        chk("t3 err", err, 1);
        chk("t3 no div_start", n_start - s0, 0);
        req = '0;

        // 4: divider hang, then recovery
        step();
        hang = 1'b1;
        r0 = n_drst;
        put(3, 8'd77, 8'd5);
        wait_done("t4");
        chk("t4 done_id", done_id, 3);
        chk("t4 err", err, 1);
        chk("t4 quotient", quotient_out, 0);
        chk("t4 remainder", remainder_out, 0);
        chk("t4 div_reset cycles", n_drst - r0, 1);
        req = '0;
        hang = 1'b0;
        step();
        put(0, 8'd9, 8'd3);
        wait_done("t4b");
        chk("t4b quotient", quotient_out, 3);
        chk("t4b remainder", remainder_out, 0);
        chk("t4b err", err, 0);
        req = '0;

        // 5: reset in mid-WAIT
        step();
        put(2, 8'd200, 8'd9);
        gcnt = 0;
        while (!div_start && gcnt < 50) begin
            step();
            gcnt++;
        end
        chk("t5 start seen", gcnt < 50, 1);
        repeat (2) step();
        d0 = n_done;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5 busy immediate", busy, 0);
        chk("t5 grant immediate", grant, 0);
        chk("t5 div_reset immediate", div_reset, 1);
        chk("t5 done immediate", done, 0);
        req = '0;
        repeat (2) step();
        reset = 1'b1;
        repeat (8) step();
        chk("t5 no done after reset", n_done - d0, 0);
        put(1, 8'd20, 8'd6);
        wait_done("t5b");
        chk("t5b done_id", done_id, 1);
        chk("t5b quotient", quotient_out, 3);
        chk("t5b remainder", remainder_out, 2);
        req = '0;

        // 6: requester drops mid-operation while a stale end flag is up
        step();
        put(1, 8'd50, 8'd4);
        gcnt = 0;
        while (grant == '0 && gcnt < 50) begin
            step();
            gcnt++;
        end
        chk("t6 grant seen", gcnt < 50, 1);
        repeat (2) step();
        req[1] = 1'b0;
        wait_done("t6");
        chk("t6 done_id", done_id, 1);
        chk("t6 quotient", quotient_out, 12);
        chk("t6 remainder", remainder_out, 2);
        chk("t6 err", err, 0);
        gcnt = 0;
        repeat (20) begin
            step();
            if (grant != '0) gcnt++;
        end
        chk("t6 no regrant", gcnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
